// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths and FSM encoding for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rf_bypass_mux.sv
// Write-to-read bypass for one register-file read port.
import rf_wport_arbiter_pkg::*;

module rf_bypass_mux (
    input  logic                  wen,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr,
    input  logic [XLEN-1:0]       rf_rdata,
    output logic [XLEN-1:0]       rdata
);

    // Forward the in-flight write; x0 reads always see the raw regfile value.
    always_comb begin
        rdata = rf_rdata;
        if (wen && (raddr == waddr) && (raddr != '0))
            rdata = wdata;
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single regfile write port between the WB stage (fixed priority)
// and a long-latency unit parked in a 1-entry hold buffer.
import rf_wport_arbiter_pkg::*;

module rf_wport_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT+1)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_addr,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2,
    output logic                  stall_req,
    output logic                  waw_err,
    output logic                  proto_err
);

    arb_state_e            state, state_nxt;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic [REG_ADDR_W-1:0] hold_addr;
    logic [XLEN-1:0]       hold_data;
    logic                  hold_v;
    logic                  lu_xfer;

    assign hold_v    = (state != IDLE);
    assign lu_ready  = ~hold_v;
    assign lu_xfer   = lu_valid & lu_ready;
    assign stall_req = (state == STALL);

    // Write mux: WB wins, else the held entry; an x0 target is consumed silently.
    always_comb begin
        rf_waddr = hold_addr;
        rf_wdata = hold_data;
        rf_wen   = hold_v;
        if (wb_valid) begin
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
            rf_wen   = 1'b1;
        end
        if (rf_waddr == '0)
            rf_wen = 1'b0;
    end

    // Next-state and starvation counter; the held entry drains on any WB-idle cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            IDLE: begin
                if (lu_xfer) begin
                    state_nxt    = HOLD;
                    wait_cnt_nxt = '0;
                end
            end
            HOLD: begin
                if (!wb_valid) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    if (wait_cnt != CNT_W'(MAX_WAIT))
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    if (wait_cnt == CNT_W'(MAX_WAIT-1))
                        state_nxt = STALL;
                end
            end
            STALL: begin
                if (!wb_valid) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // State, counter and hold buffer registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (lu_xfer) begin
                hold_addr <= lu_addr;
                hold_data <= lu_data;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            waw_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (wb_valid && hold_v && (wb_addr == hold_addr) && (wb_addr != '0))
                waw_err <= 1'b1;
            if (wb_valid && stall_req)
                proto_err <= 1'b1;
        end
    end

    rf_bypass_mux u_byp1 (
        .wen      (rf_wen),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr    (raddr1),
        .rf_rdata (rf_rdata1),
        .rdata    (rdata1)
    );

    rf_bypass_mux u_byp2 (
        .wen      (rf_wen),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr    (raddr2),
        .rf_rdata (rf_rdata2),
        .rdata    (rdata2)
    );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        srst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] rdata1, rdata2;
    logic        stall_req;
    logic        waw_err;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .srst      (srst),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .stall_req (stall_req),
        .waw_err   (waw_err),
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        srst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
        raddr1 = '0; raddr2 = '0; rf_rdata1 = 32'hAAAA_AAAA; rf_rdata2 = 32'hBBBB_BBBB;
        tick();
        srst = 1'b0;
        #1;
        chk("rst_lu_ready", 32'(lu_ready), 1);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_wen", 32'(rf_wen), 0);
        chk("rst_waw", 32'(waw_err), 0);
        chk("rst_proto", 32'(proto_err), 0);

        // LU only: accept, then write one cycle later
        lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hDEAD_BEEF;
        #1;
        chk("lu_ready_acc", 32'(lu_ready), 1);
        chk("lu_no_passthru", 32'(rf_wen), 0);
        tick();
        lu_valid = 1'b0;
        #1;
        chk("lu_wen", 32'(rf_wen), 1);
        chk("lu_waddr", 32'(rf_waddr), 5);
        chk("lu_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("lu_ready_held", 32'(lu_ready), 0);
        tick();
        chk("lu_ready_again", 32'(lu_ready), 1);
        chk("lu_wen_done", 32'(rf_wen), 0);

        // WB to x0 is filtered
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1;
        #1;
        chk("wb_x0_wen", 32'(rf_wen), 0);

        // WB write with bypass on port 1, x0 read on port 2
        wb_addr = 5'd3; wb_data = 32'h1234_5678; raddr1 = 5'd3; raddr2 = 5'd0;
        #1;
        chk("wb_wen", 32'(rf_wen), 1);
        chk("wb_waddr", 32'(rf_waddr), 3);
        chk("byp_rdata1", rdata1, 32'h1234_5678);
        chk("byp_rdata2_x0", rdata2, 32'hBBBB_BBBB);
        raddr2 = 5'd4;
        #1;
        chk("byp_rdata2_miss", rdata2, 32'hBBBB_BBBB);
        raddr1 = 5'd0;
        tick();

        // Starvation: LU entry to x7 held while WB writes x10 every cycle
        wb_addr = 5'd10; wb_data = 32'hA0A0_A0A0;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h0000_0077;
        tick();                          // accept edge
        lu_valid = 1'b0;
        #1;
        chk("starve_wb_wins", 32'(rf_waddr), 10);
        tick(); tick(); tick();          // 3 edges after accept
        chk("starve_no_stall_3", 32'(stall_req), 0);
        tick();                          // 4 edges after accept
        chk("starve_stall_4", 32'(stall_req), 1);
        wb_valid = 1'b0;
        #1;
        chk("drain_wen", 32'(rf_wen), 1);
        chk("drain_waddr", 32'(rf_waddr), 7);
        chk("drain_wdata", rf_wdata, 32'h0000_0077);
        tick();
        chk("drain_stall_clr", 32'(stall_req), 0);
        chk("drain_lu_ready", 32'(lu_ready), 1);
        chk("drain_no_proto", 32'(proto_err), 0);

        // LU entry to x0 drains silently
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h5;
        tick();
        lu_valid = 1'b0;
        #1;
        chk("x0hold_lu_ready", 32'(lu_ready), 0);
        chk("x0hold_wen", 32'(rf_wen), 0);
        tick();
        chk("x0hold_cleared", 32'(lu_ready), 1);

        // WAW: WB hits the held register
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h0000_0900;
        tick();
        lu_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
        #1;
        chk("waw_wb_wins", rf_wdata, 32'h0000_0099);
        tick();
        chk("waw_set", 32'(waw_err), 1);
        wb_valid = 1'b0;
        #1;
        chk("waw_drain_wdata", rf_wdata, 32'h0000_0900);
        chk("waw_drain_wen", 32'(rf_wen), 1);
        tick();
        chk("waw_sticky", 32'(waw_err), 1);

        // Protocol error: WB keeps writing while stalled
        lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h0000_000C;
        tick();
        lu_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd13; wb_data = 32'hD;
        tick(); tick(); tick(); tick();
        chk("proto_stall", 32'(stall_req), 1);
        chk("proto_not_yet", 32'(proto_err), 0);
        tick();
        chk("proto_set", 32'(proto_err), 1);
        chk("proto_still_stall", 32'(stall_req), 1);

        // Reset while stalled discards the held x12 entry
        srst = 1'b1;
        tick();
        srst = 1'b0; wb_valid = 1'b0;
        #1;
        chk("mid_rst_lu_ready", 32'(lu_ready), 1);
        chk("mid_rst_stall", 32'(stall_req), 0);
        chk("mid_rst_waw", 32'(waw_err), 0);
        chk("mid_rst_proto", 32'(proto_err), 0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_write", 32'(rf_wen), 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the run in case the stimulus ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the register file's single write port between two writers:
  - the pipeline WB stage, which has fixed priority and no backpressure;
  - a long-latency unit (LU, e.g. mul/div), which uses a valid/ready handshake.
- A 1-entry hold buffer parks LU results. A starvation counter raises a pipeline stall request so the LU result eventually drains.
- Also provides write-to-read bypass on both register-file read ports, because the register file updates only at the clock edge.
- Sits between the WB stage, the LU and regfile.

Parameters:
- MAX_WAIT, 4, cycles a held LU result may be blocked by WB before stall_req asserts (legal range >= 1).
- CNT_W, $clog2(MAX_WAIT+1), width of the wait counter (derived; never overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- srst  in  1  synchronous reset, active-high.
- wb_valid  in  1  WB stage writes this cycle.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- lu_valid  in  1  LU result available.
- lu_ready  out  1  arbiter accepts the LU result this cycle.
- lu_addr  in  5  LU destination register.
- lu_data  in  32  LU result data.
- rf_wen  out  1  regfile write enable.
- rf_waddr  out  5  regfile write address.
- rf_wdata  out  32  regfile write data.
- raddr1, raddr2  in  5 each  read addresses presented to the regfile.
- rf_rdata1, rf_rdata2  in  32 each  raw regfile read data.
- rdata1, rdata2  out  32 each  bypassed read data.
- stall_req  out  1  request that the pipeline issue no WB write next cycle.
- waw_err  out  1  sticky error: WB and the held entry target the same nonzero register.
- proto_err  out  1  sticky error: wb_valid asserted while stall_req=1.

Behaviour:
- Reset (srst=1 at the edge):
  - state=IDLE, hold_v=0, wait_cnt=0, waw_err=0, proto_err=0.
  - Hold address and data are cleared to 0.
  - Consequently lu_ready=1, stall_req=0 and rf_wen=0 unless wb_valid.
  - Reset mid-operation discards any held result without writing it.
- Write mux (combinational, 0 latency):
  - If wb_valid: rf_* = wb_*.
  - Else if hold_v: rf_* = hold entry, and the entry drains (hold_v clears at the next edge).
  - Else rf_wen=0.
  - rf_wen is forced to 0 whenever the selected address is 0; an x0 write counts as drained/consumed.
- Handshake:
  - lu_ready = ~hold_v.
  - A transfer occurs when lu_valid & lu_ready; the entry is captured at that edge.
  - Minimum latency is accept in cycle N, regfile write in cycle N+1.
  - No same-cycle pass-through from the LU to the regfile.
- FSM (hold_v=1 exactly in HOLD and STALL):
  - IDLE: on an LU transfer -> HOLD, wait_cnt=0.
  - HOLD:
    - if ~wb_valid: drain -> IDLE;
    - else wait_cnt+1, and if wait_cnt==MAX_WAIT-1 -> STALL.
  - STALL: stall_req=1 (Moore output).
    - if ~wb_valid: drain -> IDLE, wait_cnt=0;
    - else stay in STALL and set proto_err.
  - wait_cnt saturates; it never wraps.
- waw_err is set when wb_valid & hold_v & wb_addr==hold_addr & wb_addr!=0. WB still wins, and the held entry still drains later. Upstream scoreboarding guarantees this never occurs.
- Bypass:
  - rdataK = rf_wdata when rf_wen & raddrK==rf_waddr & raddrK!=0; otherwise rdataK = rf_rdataK.
  - Reads of x0 always pass rf_rdataK.
- Sticky errors clear only on reset.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and XLEN=32;
  - the FSM state encoding (IDLE=2'd0, HOLD=2'd1, STALL=2'd2).
- One natural sub-module: rf_bypass_mux, instantiated twice, one per read port (pure combinational compare-and-select).
- The FSM, hold register and counter stay in the top module.

Test Plan:
- LU only: lu_valid with addr=5, data=0xDEADBEEF while wb_valid=0 -> lu_ready=1; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, lu_ready=1 again the cycle after.
- Priority and starvation, MAX_WAIT=4: hold an LU entry (addr=7) while wb_valid=1 every cycle -> stall_req rises 4 cycles after the accept edge. Drop wb_valid -> addr 7 written that cycle, stall_req=0 next cycle.
- x0 filtering: wb_valid with wb_addr=0, data=0x1 -> rf_wen=0. Holding an LU entry to x0 with wb idle -> entry drains with rf_wen=0 and hold_v clears.
- Bypass: rf_wen writes addr=3, data=0x12345678; same cycle raddr1=3, raddr2=0 -> rdata1=0x12345678, rdata2=rf_rdata2.
- Errors:
  - hold addr=9 with wb_addr=9 valid -> waw_err=1 and stays 1;
  - wb_valid during stall_req -> proto_err=1;
  - srst=1 clears both errors.
- Reset mid-operation: srst in STALL with an entry held -> next cycle lu_ready=1, stall_req=0, and no write of the discarded entry ever occurs.
